demux1t4_32_buf: RTL
====================

DEMUX1T4_32_BUF -- requirements
Module: demux1t4_32_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every port.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output channel queue (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s  input  2  destination channel select (0..3) for in_data.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  word to route.
REQ-008 SHALL have port in_ready  output  1  word on in_data accepted this cycle if in_valid.
REQ-009 SHALL have ports o0_valid..o3_valid  output  1 each  channel k holds a word.
REQ-010 SHALL have ports o0_data..o3_data  output  WIDTH each  head word of channel k.
REQ-011 SHALL have ports o0_ready..o3_ready  input  1 each  consumer k takes head word.
REQ-012 SHALL have ports o0_count..o3_count  output  $clog2(DEPTH)+1 each  occupancy of channel k.

Function
REQ-013 SHALL accept a word (push) exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-014 SHALL drive in_ready = 1 iff channel s is not full (count < DEPTH), combinationally from s and registered state only; in_ready SHALL NOT depend on any ok_ready (no ready pass-through).
REQ-015 SHALL write a pushed word only into channel s; other channels unchanged.
REQ-016 SHALL drive ok_valid = 1 iff count_k > 0, and ok_data = oldest word in channel k (registered storage, no bypass).
REQ-017 SHALL pop channel k exactly when ok_valid and ok_ready are 1 at a rising edge.
REQ-018 SHALL have latency exactly 1 cycle: word pushed at edge N appears on ok_data/ok_valid after edge N, if channel k was empty.
REQ-019 SHALL preserve FIFO order per channel; no ordering relation between channels.
REQ-020 SHALL support simultaneous push and pop on the same non-full channel: count unchanged, head advances, new word queued behind.
REQ-021 SHALL, with channel full and ok_ready=1, still hold in_ready=0 that cycle; push possible the following cycle.
REQ-022 SHALL ignore ok_ready when ok_valid=0 (no count underflow, pointers unchanged).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count SHALL range 0..DEPTH only.
REQ-024 SHALL allow pops on all four channels plus one push in the same cycle.
REQ-025 SHALL keep ok_data stable while ok_valid=1 and ok_ready=0.
REQ-026 SHALL treat s as don't-care when in_valid=0; in_ready still reflects channel s.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously clear all pointers and counts: ok_valid=0, ok_count=0, in_ready=1 for every s.
REQ-028 SHALL discard all queued words on reset mid-operation; ok_data value after reset is don't-care while ok_valid=0.
REQ-029 SHALL resume accepting on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place WIDTH/DEPTH defaults and the 2-bit channel-index type in a shared package.
REQ-031 SHALL instantiate one sub-module chan_fifo (push, pop, data, valid, full, count) four times; top holds only select decode and ready mux.

Verification
REQ-032 Reset then push 0x11111111 s=2 -> o2_valid=1, o2_data=0x11111111 next cycle, o0/o1/o3_valid=0, o2_count=1.
REQ-033 Push 0xA0,0xA1 to s=1 with o1_ready=0 -> o1_count=2, in_ready=0 for s=1, in_ready=1 for s=0; third push stalls; then o1_ready=1 pops 0xA0 then 0xA1 in order.
REQ-034 Channel 3 full, o3_ready=1 and push 0xB2 s=3 same cycle -> in_ready=0, 0xB2 not taken; accepted next cycle, o3_count returns to 2.
REQ-035 Channel 0 count=1, push 0xC1 s=0 with o0_ready=1 -> o0_count stays 1, o0_data=0xC1 after edge.
REQ-036 Channels 0..3 each loaded, rst_n pulsed low mid-cycle -> all ok_valid=0, counts 0 immediately, no clock edge needed.
REQ-037 Random 10k-cycle traffic with random ready -> per-channel scoreboard matches order, no loss, no duplication.

Source files
------------

// File: rtl/demux1t4_32_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux1t4_32_buf_pkg
// Brief    : Shared defaults and channel-index type for the 1-to-4 demux.
// Revision : 1.0 - initial release
// ============================================================================
package demux1t4_32_buf_pkg;

  localparam int c_def_width = 32;
  localparam int c_def_depth = 2;
  localparam int c_num_chan  = 4;

  typedef logic [1:0] chan_idx_t;

endpackage
`default_nettype wire

// File: rtl/demux1t4_32_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : demux1t4_32_buf_if
// Brief    : Producer side plus four consumer channels of the buffered demux.
// Revision : 1.0 - initial release
// ============================================================================
interface demux1t4_32_buf_if
  import demux1t4_32_buf_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int DEPTH = c_def_depth
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  chan_idx_t          s;
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;

  logic               o0_valid, o1_valid, o2_valid, o3_valid;
  logic [WIDTH-1:0]   o0_data,  o1_data,  o2_data,  o3_data;
  logic               o0_ready, o1_ready, o2_ready, o3_ready;
  logic [CW-1:0]      o0_count, o1_count, o2_count, o3_count;

  modport slave (
    input  s, in_valid, in_data,
    input  o0_ready, o1_ready, o2_ready, o3_ready,
    output in_ready,
    output o0_valid, o1_valid, o2_valid, o3_valid,
    output o0_data,  o1_data,  o2_data,  o3_data,
    output o0_count, o1_count, o2_count, o3_count
  );

  modport master (
    output s, in_valid, in_data,
    output o0_ready, o1_ready, o2_ready, o3_ready,
    input  in_ready,
    input  o0_valid, o1_valid, o2_valid, o3_valid,
    input  o0_data,  o1_data,  o2_data,  o3_data,
    input  o0_count, o1_count, o2_count, o3_count
  );

endinterface
`default_nettype wire

// File: rtl/demux1t4_32_buf_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : chan_fifo
// Brief    : Per-channel registered FIFO; head word is read straight from storage.
// Revision : 1.0 - initial release
// ============================================================================
module chan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  // A full channel refuses a push even if it is being popped this cycle.
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; contents are ignored while count is zero.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign data  = r_mem[r_rd_ptr];
  assign valid = (r_count != '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/demux1t4_32_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux1t4_32_buf
// Brief    : Routes one input stream into four buffered output channels by s.
// Revision : 1.0 - initial release
// ============================================================================
module demux1t4_32_buf
  import demux1t4_32_buf_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int DEPTH = c_def_depth
) (
  input  logic                   clk,
  input  logic                   rst_n,
  demux1t4_32_buf_if.slave       bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]       w_ready;
  logic [3:0]       w_push;
  logic [3:0]       w_valid;
  logic [3:0]       w_full;
  logic [WIDTH-1:0] w_data  [c_num_chan];
  logic [CW-1:0]    w_count [c_num_chan];

  assign w_ready = {bus.o3_ready, bus.o2_ready, bus.o1_ready, bus.o0_ready};

  // Ready depends only on the selected channel's stored occupancy.
  assign bus.in_ready = ~w_full[bus.s];

  always_comb begin
    w_push         = '0;
    w_push[bus.s]  = bus.in_valid & bus.in_ready;
  end

  generate
    for (genvar k = 0; k < c_num_chan; k++) begin : g_chan
      chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push[k]),
        .push_data (bus.in_data),
        .pop       (w_ready[k]),
        .data      (w_data[k]),
        .valid     (w_valid[k]),
        .full      (w_full[k]),
        .count     (w_count[k])
      );
    end
  endgenerate

  assign bus.o0_valid = w_valid[0];
  assign bus.o1_valid = w_valid[1];
  assign bus.o2_valid = w_valid[2];
  assign bus.o3_valid = w_valid[3];
  assign bus.o0_data  = w_data[0];
  assign bus.o1_data  = w_data[1];
  assign bus.o2_data  = w_data[2];
  assign bus.o3_data  = w_data[3];
  assign bus.o0_count = w_count[0];
  assign bus.o1_count = w_count[1];
  assign bus.o2_count = w_count[2];
  assign bus.o3_count = w_count[3];

endmodule
`default_nettype wire
